// File: rtl/logisim_tick_pkg.sv
// Shared encodings for the tick run-control block: command opcodes and FSM states.
package logisim_tick_pkg;

    // Command opcodes carried on cmdOp
    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    // Scheduler states; LOADWAIT is the one-cycle settle after a period reload
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STEP     = 2'd2,
        ST_LOADWAIT = 2'd3
    } tick_state_e;

endpackage

// File: rtl/logisim_tick_counter.sv
// Loadable down-counter with enable and zero flag; load has priority over enable.
module logisim_tick_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins, else decrement when enabled, else hold
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register with synchronous reset to zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/logisim_tick_controller.sv
// Command-driven tick scheduler: STOP / RUN / STEP-N / LOAD period, one-cycle
// FPGATick pulse per period while running.
//
// Handshake: a command is accepted on a rising edge where cmdValid && cmdReady;
// cmdOp/cmdData are only looked at on that edge. cmdReady is low only in
// LOADWAIT, so the host never has to hold a command more than one extra cycle.
module logisim_tick_controller
    import logisim_tick_pkg::*;
#(
    parameter int nrOfBits      = 16,
    parameter int stepBits      = 8,
    parameter int defaultReload = 1
) (
    input  logic                FPGAClock,
    input  logic                FPGAReset,
    input  logic                cmdValid,
    output logic                cmdReady,
    input  logic [1:0]          cmdOp,
    input  logic [nrOfBits-1:0] cmdData,
    output logic                FPGATick,
    output logic                running,
    output logic [stepBits-1:0] stepsLeft,
    output logic                stepDone,
    output logic [1:0]          dbgState
);

    localparam logic [nrOfBits-1:0] RELOAD_ONE  = nrOfBits'(1);
    localparam logic [nrOfBits-1:0] RELOAD_INIT = nrOfBits'(defaultReload);

    tick_state_e         state_q, state_d;
    tick_state_e         ret_q, ret_d;
    logic [nrOfBits-1:0] reload_q, reload_d;
    logic [stepBits-1:0] steps_q, steps_d;
    logic                tick_q, tick_d;
    logic                done_q, done_d;

    logic                accept;
    logic                cmd_live;
    logic                active;
    logic                tick_en;
    logic [stepBits-1:0] step_n;
    logic                cnt_load;
    logic                cnt_en;
    logic                cnt_zero;

    assign accept   = cmdValid && cmdReady;
    assign step_n   = cmdData[stepBits-1:0];
    // STEP 0 is accepted but behaves as if nothing arrived, so it must not
    // disturb the running period or suppress a due tick.
    assign cmd_live = accept && !((cmdOp == OP_STEP) && (step_n == '0));
    assign active   = (state_q == ST_RUN) || (state_q == ST_STEP);
    // An accepted command owns the edge: it replaces any tick that was due.
    assign tick_en  = active && cnt_zero && !cmd_live;

    // Next-state, register updates and counter control
    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        reload_d = reload_q;
        steps_d  = steps_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        if (cmd_live) begin
            case (cmdOp)
                OP_STOP: begin
                    state_d = ST_IDLE;
                    steps_d = '0;
                end
                OP_RUN: begin
                    state_d  = ST_RUN;
                    steps_d  = '0;
                    cnt_load = 1'b1;
                end
                OP_STEP: begin
                    state_d  = ST_STEP;
                    steps_d  = step_n;
                    cnt_load = 1'b1;
                end
                default: begin
                    reload_d = (cmdData == '0) ? RELOAD_ONE : cmdData;
                    ret_d    = active ? state_q : ST_IDLE;
                    state_d  = ST_LOADWAIT;
                end
            endcase
        end else if (state_q == ST_LOADWAIT) begin
            // Resume with a fresh period at the new reload; IDLE keeps its count
            state_d = ret_q;
            if (ret_q != ST_IDLE) begin
                cnt_load = 1'b1;
            end
        end else if (tick_en) begin
            cnt_load = 1'b1;
            tick_d   = 1'b1;
            if ((state_q == ST_STEP) && (steps_q != '0)) begin
                steps_d = steps_q - stepBits'(1);
                if (steps_q == stepBits'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        end else if (active) begin
            cnt_en = 1'b1;
        end
    end

    // State and output registers; reset overrides any command on the same edge
    always_ff @(posedge FPGAClock) begin
        if (FPGAReset) begin
            state_q  <= ST_IDLE;
            ret_q    <= ST_IDLE;
            reload_q <= RELOAD_INIT;
            steps_q  <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            reload_q <= reload_d;
            steps_q  <= steps_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    // reload_q is already the new period when LOADWAIT reloads the counter
    logisim_tick_counter #(
        .W(nrOfBits)
    ) u_counter (
        .clk_i      (FPGAClock),
        .rst_i      (FPGAReset),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i (reload_q - RELOAD_ONE),
        .zero_o     (cnt_zero)
    );

    assign cmdReady  = (state_q != ST_LOADWAIT);
    assign running   = active || ((state_q == ST_LOADWAIT) && (ret_q != ST_IDLE));
    assign FPGATick  = tick_q;
    assign stepDone  = done_q;
    assign stepsLeft = steps_q;
    assign dbgState  = state_q;

endmodule

// File: tb/tb_logisim_tick_controller.sv
// Self-checking bench for logisim_tick_controller: expected per-cycle outputs
// are derived from the period/step formulas and queued as each command is driven.
module tb_logisim_tick_controller;
    import logisim_tick_pkg::*;

    // ---------------- clock / reset ----------------
    logic        FPGAClock = 1'b0;
    logic        FPGAReset = 1'b1;
    logic        cmdValid  = 1'b0;
    logic [1:0]  cmdOp     = 2'b00;
    logic [15:0] cmdData   = 16'd0;
    logic        cmdReady;
    logic        FPGATick;
    logic        running;
    logic [7:0]  stepsLeft;
    logic        stepDone;
    logic [1:0]  dbgState;

    always #5 FPGAClock = ~FPGAClock;

    logisim_tick_controller #(
        .nrOfBits      (16),
        .stepBits      (8),
        .defaultReload (1)
    ) dut (
        .FPGAClock (FPGAClock),
        .FPGAReset (FPGAReset),
        .cmdValid  (cmdValid),
        .cmdReady  (cmdReady),
        .cmdOp     (cmdOp),
        .cmdData   (cmdData),
        .FPGATick  (FPGATick),
        .running   (running),
        .stepsLeft (stepsLeft),
        .stepDone  (stepDone),
        .dbgState  (dbgState)
    );

    // ---------------- scoreboard ----------------
    // Packed expectation: {ready, running, tick, done, stepsLeft[7:0]}
    logic [11:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic push_exp(input logic rdy, input logic run, input logic tck,
                            input logic dn, input logic [7:0] st);
        exp_q.push_back({rdy, run, tck, dn, st});
    endtask

    // ---------------- driver ----------------
    // Drive one command slot, advance one rising edge, then compare the
    // post-edge outputs against the oldest queued expectation.
    task automatic cycle(input logic v, input logic [1:0] op, input logic [15:0] d);
        logic [11:0] e;
        cmdValid = v;
        cmdOp    = op;
        cmdData  = d;
        @(posedge FPGAClock);
        @(negedge FPGAClock);
        cmdValid = 1'b0;
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("cmdReady",  32'(cmdReady),  32'(e[11]));
            check_eq("running",   32'(running),   32'(e[10]));
            check_eq("FPGATick",  32'(FPGATick),  32'(e[9]));
            check_eq("stepDone",  32'(stepDone),  32'(e[8]));
            check_eq("stepsLeft", 32'(stepsLeft), 32'(e[7:0]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            push_exp(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
            cycle(1'b0, OP_STOP, 16'd0);
        end
    endtask

    task automatic stop_cmd();
        push_exp(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b1, OP_STOP, 16'd0);
    endtask

    // LOAD from IDLE: one cycle with cmdReady low, then back to IDLE
    task automatic load_idle(input int d);
        push_exp(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b1, OP_LOAD, 16'(d));
        push_exp(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, OP_STOP, 16'd0);
    endtask

    // RUN at edge j=0 with period r: tick visible after edges r, 2r, ...
    task automatic run_seq(input int r, input int n_after);
        push_exp(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        cycle(1'b1, OP_RUN, 16'd0);
        for (int j = 1; j <= n_after; j++) begin
            push_exp(1'b1, 1'b1, (j % r) == 0, 1'b0, 8'd0);
            cycle(1'b0, OP_STOP, 16'd0);
        end
    endtask

    // STEP n at edge j=0 with period r: ticks after edges r..n*r, last one done
    task automatic step_seq(input int r, input int n, input int n_after);
        int left;
        push_exp(1'b1, 1'b1, 1'b0, 1'b0, 8'(n));
        cycle(1'b1, OP_STEP, 16'(n));
        for (int j = 1; j <= n_after; j++) begin
            left = (j / r >= n) ? 0 : n - j / r;
            push_exp(1'b1, j < n * r, ((j % r) == 0) && (j <= n * r),
                     j == n * r, 8'(left));
            cycle(1'b0, OP_STOP, 16'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        push_exp(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, OP_STOP, 16'd0);
        push_exp(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, OP_STOP, 16'd0);
        check_eq("state_reset", 32'(dbgState), 32'(ST_IDLE));
        FPGAReset = 1'b0;

        // Default period 1: low one cycle, then continuously high
        run_seq(1, 5);
        stop_cmd();
        idle(2);

        // Period 4 from IDLE
        push_exp(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b1, OP_LOAD, 16'd4);
        check_eq("state_loadwait", 32'(dbgState), 32'(ST_LOADWAIT));
        push_exp(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, OP_STOP, 16'd0);
        run_seq(4, 13);
        stop_cmd();

        // Period 3, STEP 2
        load_idle(3);
        step_seq(3, 2, 9);

        // Period 5, STOP on the edge a tick is due, then full restart
        load_idle(5);
        run_seq(5, 4);
        stop_cmd();
        idle(3);
        run_seq(5, 11);
        stop_cmd();

        // LOAD 0 behaves as period 1
        load_idle(0);
        run_seq(1, 4);
        stop_cmd();

        // STEP 0 while running at period 3, issued on a tick edge
        load_idle(3);
        push_exp(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        cycle(1'b1, OP_RUN, 16'd0);
        for (int j = 1; j <= 9; j++) begin
            push_exp(1'b1, 1'b1, (j % 3) == 0, 1'b0, 8'd0);
            cycle(j == 3, OP_STEP, 16'd0);
        end

        // LOAD 2 while running: LOADWAIT keeps running high, new period follows
        push_exp(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        cycle(1'b1, OP_LOAD, 16'd2);
        for (int n = 1; n <= 6; n++) begin
            push_exp(1'b1, 1'b1, (n >= 3) && (((n - 1) % 2) == 0), 1'b0, 8'd0);
            cycle(1'b0, OP_STOP, 16'd0);
        end
        stop_cmd();

        // Reset mid-STEP with a command present: command ignored, no stepDone
        load_idle(2);
        step_seq(2, 5, 4);
        FPGAReset = 1'b1;
        push_exp(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b1, OP_RUN, 16'd0);
        FPGAReset = 1'b0;
        idle(3);
        check_eq("state_after_reset", 32'(dbgState), 32'(ST_IDLE));

        // ---------------- report ----------------
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/logisim_tick_controller.md
Name: logisim_tick_controller

Overview:
Run-control scheduler for the simulated-circuit clock tick. Replaces the free-running fixed-reload tick with a command-driven one that supports STOP, RUN, STEP-N and a run-time reloadable period. It sits between the board clock domain and the Logisim clock components. It takes commands from the host/button interface over a valid/ready port and emits a one-cycle FPGATick pulse per period while enabled.

Parameters:
nrOfBits, 16, width of period counter and reload register
stepBits, 8, width of step counter
defaultReload, 1, period in FPGAClock cycles after reset (must be >= 1)

Ports:
FPGAClock  in  1  board clock, all logic rising-edge
FPGAReset  in  1  synchronous, active-high reset
cmdValid  in  1  command present
cmdReady  out  1  command accepted when cmdValid && cmdReady at rising edge
cmdOp  in  2  00 STOP, 01 RUN, 10 STEP, 11 LOAD
cmdData  in  nrOfBits  LOAD: new period; STEP: step count in [stepBits-1:0]
FPGATick  out  1  registered one-cycle tick pulse
running  out  1  high in RUN or STEP state
stepsLeft  out  stepBits  remaining ticks in STEP state, 0 otherwise
stepDone  out  1  one-cycle pulse when final STEP tick is issued

Behaviour:
- One clock; reset is synchronous and active-high. Clock is FPGAClock, reset is FPGAReset.
- Reset values: state IDLE, reloadReg=defaultReload, countReg=0, FPGATick=0, stepsLeft=0, stepDone=0, running=0, cmdReady=1. Reset overrides any command in the same cycle.
- States: IDLE, RUN, STEP, LOADWAIT (plus the return state held for LOADWAIT).
- Period R = reloadReg. A LOAD with cmdData=0 stores 1, so R >= 1 always.
- Counter: a tick enable fires when countReg==0 in RUN/STEP. On that edge countReg <= R-1, otherwise countReg <= countReg-1. In IDLE, countReg holds. FPGATick is registered: it is high in the cycle after the enable edge.
- RUN accepted at edge k: countReg <= R-1. The first FPGATick is high in the cycle after edge k+R, and subsequent ticks follow every R cycles. For R=1, FPGATick is continuously high.
- STEP N accepted, N!=0: countReg <= R-1 and stepsLeft <= N. Each tick decrements stepsLeft. The tick that takes stepsLeft 1->0 also moves state to IDLE, and stepDone pulses with that FPGATick. STEP N=0 is accepted and is a no-op; the state is unchanged.
- RUN or STEP accepted while already RUN/STEP: the counter restarts at R-1. STEP replaces any remaining steps; RUN clears stepsLeft.
- STOP accepted: state goes to IDLE at that edge, FPGATick <= 0 at that edge (a pending tick is suppressed), and stepsLeft <= 0. stepDone does not pulse.
- LOAD accepted: reloadReg <= max(cmdData,1) and state goes to LOADWAIT for exactly 1 cycle with cmdReady=0. Then it returns to the prior state with countReg <= newR-1; in IDLE, countReg is left unchanged. No tick is issued during LOADWAIT.
- cmdReady=1 in every state except LOADWAIT. Commands with cmdValid low are ignored. cmdOp/cmdData are sampled only on acceptance.
- Counter arithmetic is unsigned nrOfBits wide. stepsLeft never underflows.
- running = (state==RUN || state==STEP), or LOADWAIT entered from those states.

Decomposition:
- Package logisim_tick_pkg: cmdOp encodings (OP_STOP/OP_RUN/OP_STEP/OP_LOAD) and state encoding constants.
- Sub-module logisim_tick_counter: loadable nrOfBits down-counter with enable, synchronous load and zero flag. It is instantiated once, and the FSM drives load/enable.

Test Plan:
- Reset, R=defaultReload=1, RUN -> FPGATick low for 1 cycle, then high every cycle; running=1; cmdReady=1.
- LOAD 4 in IDLE, then RUN at edge k -> cmdReady low 1 cycle after LOAD; ticks high in the cycles after edges k+4, k+8, k+12; exactly one high cycle per 4.
- LOAD 3, STEP 2 -> exactly 2 ticks spaced 3 cycles; stepDone coincides with the 2nd tick; running falls after it; stepsLeft counts 2,1,0.
- RUN with R=5, STOP on the edge where countReg==0 -> no FPGATick follows; running=0; next RUN restarts the full 5-cycle period.
- LOAD 0 -> reloadReg reads as 1. STEP 0 while RUN -> stays RUN, tick spacing unchanged.
- FPGAReset asserted mid-STEP (stepsLeft=3) while cmdValid=1 -> next cycle all outputs at reset values and the command is ignored; no stepDone.
